ttl_rr_arbiter: RTL and testbench
=================================

Name: ttl_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream gate bank (e.g. a BLOCKS-wide inverter package) among up to BLOCKS requesters. It issues a registered one-hot grant, holds it until the owner signals Done or withdraws its request, then rotates priority. The requester-facing side uses the same parameter and delay style as the rest of the 7400 library.

Parameters:
BLOCKS, 4, number of requesters (2..16)
MAX_HOLD, 8, cycles a grant may be held before forced release (used only with TTL_ARB_TIMEOUT_EN; 1..255)
DELAY_RISE, 0, output rise delay applied to every output assignment
DELAY_FALL, 0, output fall delay applied to every output assignment

Ports:
Clk  input  1  clock; all state updates on rising edge
Clear  input  1  synchronous active-high reset, sampled on Clk rising edge
Req  input  BLOCKS  request per requester, level-sensitive
Done  input  1  owner finished; sampled only while Busy=1
Grant  output  BLOCKS  one-hot grant, registered
Grant_index  output  4  binary index of current grant; 0 when idle
Busy  output  1  1 while a grant is active
Timeout  output  1  one-cycle pulse on forced release (0 without macro)

Behaviour:
- Reset (Clear=1 at edge): Grant=0, Grant_index=0, Busy=0, Timeout=0, pointer=0, hold counter=0. Clear overrides all other inputs, including mid-grant.
- State IDLE (Busy=0):
  - at edge, if any Req bit is 1, grant the first set bit scanning pointer, pointer+1, ... wrapping modulo BLOCKS; go to GRANT.
  - if no Req bit is set, stay in IDLE.
  - latency is 1 edge from Req sampled to Grant visible (+ output delay).
- State GRANT (Busy=1, Grant=one-hot bit g):
  - Release condition at an edge: Done=1 or Req[g]=0.
  - On release: pointer <= (g+1) mod BLOCKS. If any other Req is set (excluding g), grant it in the same edge (back-to-back, no idle cycle) using the new pointer. Otherwise go to IDLE with Grant=0.
  - Req[g] still 1 with Done=1 and no other requester: g is re-granted via the scan, since it is reached last by wrap-around.
- Grant is never multi-hot. Grant changes only on an edge and only on reset, grant, or release.
- Grant_index always equals the encoded Grant, and 0 when Grant=0.
- Requests arriving during GRANT are not latched; only the Req level at the release edge counts.
- Done while IDLE is ignored.
- Pointer wrap: g=BLOCKS-1 gives pointer 0.
- All outputs are driven from registers through continuous assigns with #(DELAY_RISE, DELAY_FALL).

Optional Feature:
- Macro TTL_ARB_TIMEOUT_EN.
- Defined:
  - hold counter clears on each new grant and increments every GRANT cycle.
  - when it reaches MAX_HOLD without a release, the next edge forces a release. This release behaves like Done, with the same rotation and back-to-back rules.
  - Timeout=1 for exactly one cycle after a forced release. A normal release in the same edge takes precedence, with Timeout=0.
- Undefined: no counter logic; Timeout tied 0; a grant is held indefinitely.

Test Plan:
All scenarios use BLOCKS=4, DELAY_RISE=2, DELAY_FALL=3, clock period 20, with checks 5 after the edge.
- Reset: Clear=1 for 2 edges with Req=4'b1111 -> Grant=0000, Busy=0, Grant_index=0. Release Clear -> next edge Grant=0001, Grant_index=0.
- Rotation: Req=1111 held, Done pulsed each cycle -> Grant sequence 0001,0010,0100,1000,0001 (wrap), Busy stays 1 throughout.
- Withdraw/idle: only Req=0100 -> Grant=0100. Drop Req[2] -> next edge Grant=0000, Busy=0. Then Req=0110 -> Grant=1000 not set; Grant=0010 because pointer=3 scan wraps 3,0,1.
- Hold: Req=0001 held, Done=0 for 20 cycles -> Grant stays 0001, Timeout=0 (macro undefined). Req=1001 at release with Done=1 -> back-to-back Grant=1000.
- Clear mid-grant: Grant=0100 active, Clear=1 -> next edge Grant=0000, pointer=0. With Req=0110 after Clear -> Grant=0010.
- Timeout (TTL_ARB_TIMEOUT_EN, MAX_HOLD=3): Req=0011, no Done -> Grant=0001 for 3 cycles, then Grant=0010 with Timeout=1 for one cycle, then Timeout=0.

Source files
------------

// File: rtl/ttl_rr_arbiter.sv
// Round-robin arbiter sharing one gate bank among BLOCKS requesters with registered one-hot grant.
// Optional forced release after MAX_HOLD cycles is enabled by defining TTL_ARB_TIMEOUT_EN.
module ttl_rr_arbiter #(
   parameter int BLOCKS     = 4,
   parameter int MAX_HOLD   = 8,
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic              Clk,
   input  logic              Clear,
   input  logic [BLOCKS-1:0] Req,
   input  logic              Done,
   output logic [BLOCKS-1:0] Grant,
   output logic [3:0]        Grant_index,
   output logic              Busy,
   output logic              Timeout
);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   localparam logic [3:0] LAST_IDX = 4'(BLOCKS - 1);

   state_t            state_q, state_d;
   logic [BLOCKS-1:0] grant_q, grant_d;
   logic [3:0]        idx_q, idx_d;
   logic [3:0]        ptr_q, ptr_d;
   logic [3:0]        nxt_ptr;
   logic [3:0]        pick_idx;
   logic [BLOCKS-1:0] pick_oh;
   logic              found;
   logic              rel;
   logic              forced;
`ifdef TTL_ARB_TIMEOUT_EN
   logic [7:0]        hold_q, hold_d;
   logic              tmo_q, tmo_d;
`endif

   // Scan a doubled request vector shifted by the start point, so the first set bit is the winner.
   function automatic logic rr_pick(input logic [BLOCKS-1:0] req, input logic [3:0] start,
                                    output logic [3:0] idx, output logic [BLOCKS-1:0] onehot);
      logic [2*BLOCKS-1:0] dbl;
      logic [4:0]          pos;
      logic                hit;
      hit    = 1'b0;
      idx    = '0;
      onehot = '0;
      dbl    = {req, req} >> start;
      for (int k = 0; k < BLOCKS; k++) begin
         if (!hit && dbl[k]) begin
            hit = 1'b1;
            pos = {1'b0, start} + 5'(k);
            if (pos >= 5'(BLOCKS)) pos = pos - 5'(BLOCKS);
            idx    = pos[3:0];
            onehot = {{(BLOCKS-1){1'b0}}, 1'b1} << pos[3:0];
         end
      end
      return hit;
   endfunction

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      idx_d    = idx_q;
      ptr_d    = ptr_q;
      nxt_ptr  = ptr_q;
      pick_idx = '0;
      pick_oh  = '0;
      found    = 1'b0;
      rel      = 1'b0;
      forced   = 1'b0;
`ifdef TTL_ARB_TIMEOUT_EN
      hold_d   = hold_q;
      tmo_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            found = rr_pick(Req, ptr_q, pick_idx, pick_oh);
            if (found) begin
               state_d = ST_GRANT;
               grant_d = pick_oh;
               idx_d   = pick_idx;
`ifdef TTL_ARB_TIMEOUT_EN
               hold_d  = '0;
`endif
            end
         end
         ST_GRANT: begin
            // The owner's request is picked out by masking with the current grant.
            rel = Done | ~(|(Req & grant_q));
`ifdef TTL_ARB_TIMEOUT_EN
            forced = ~rel & (hold_q == 8'(MAX_HOLD - 1));
`endif
            if (rel | forced) begin
               nxt_ptr = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
               ptr_d   = nxt_ptr;
               found   = rr_pick(Req, nxt_ptr, pick_idx, pick_oh);
               if (found) begin
                  grant_d = pick_oh;
                  idx_d   = pick_idx;
               end else begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  idx_d   = '0;
               end
`ifdef TTL_ARB_TIMEOUT_EN
               hold_d = '0;
               tmo_d  = forced;
            end else begin
               hold_d = hold_q + 8'd1;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Clear) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
`ifdef TTL_ARB_TIMEOUT_EN
         hold_q  <= '0;
         tmo_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
`ifdef TTL_ARB_TIMEOUT_EN
         hold_q  <= hold_d;
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign #(DELAY_RISE, DELAY_FALL) Grant       = grant_q;
   assign #(DELAY_RISE, DELAY_FALL) Grant_index = idx_q;
   assign #(DELAY_RISE, DELAY_FALL) Busy        = (state_q == ST_GRANT);
`ifdef TTL_ARB_TIMEOUT_EN
   assign #(DELAY_RISE, DELAY_FALL) Timeout     = tmo_q;
`else
   assign #(DELAY_RISE, DELAY_FALL) Timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_ttl_rr_arbiter.sv
// Self-checking bench for ttl_rr_arbiter: directed scenarios plus randomized traffic
// compared against a round-robin reference model.
module tb_ttl_rr_arbiter;

`ifdef TTL_ARB_TIMEOUT_EN
   localparam int MAXH = 3;
`else
   localparam int MAXH = 8;
`endif
   localparam int B = 4;

   logic       Clk = 1'b0;
   logic       Clear = 1'b1;
   logic [3:0] Req = '0;
   logic       Done = 1'b0;
   logic [3:0] Grant;
   logic [3:0] Grant_index;
   logic       Busy;
   logic       Timeout;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: owner (-1 when idle), priority start, cycles the grant has been visible.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_vis   = 0;
   bit m_tmo   = 1'b0;

   ttl_rr_arbiter #(
      .BLOCKS(B), .MAX_HOLD(MAXH), .DELAY_RISE(2), .DELAY_FALL(3)
   ) dut (
      .Clk(Clk), .Clear(Clear), .Req(Req), .Done(Done),
      .Grant(Grant), .Grant_index(Grant_index), .Busy(Busy), .Timeout(Timeout)
   );

   always #10 Clk = ~Clk;

   function automatic int first_from(input logic [3:0] req, input int start);
      for (int k = 0; k < B; k++)
         if (req[(start + k) % B]) return (start + k) % B;
      return -1;
   endfunction

   task automatic model_edge(input logic [3:0] req, input logic done, input logic clr);
      bit force_rel;
      m_tmo = 1'b0;
      if (clr) begin
         m_owner = -1; m_ptr = 0; m_vis = 0;
      end else if (m_owner < 0) begin
         m_owner = first_from(req, m_ptr);
         m_vis   = 1;
      end else begin
         force_rel = 1'b0;
`ifdef TTL_ARB_TIMEOUT_EN
         force_rel = (m_vis >= MAXH);
`endif
         if (done || !req[m_owner] || force_rel) begin
            m_tmo   = force_rel && !done && req[m_owner];
            m_ptr   = (m_owner + 1) % B;
            m_owner = first_from(req, m_ptr);
            m_vis   = 1;
         end else begin
            m_vis = m_vis + 1;
         end
      end
   endtask

   // Drive inputs, let one edge pass, advance the model, then settle past the output delays.
   task automatic cycle(input logic [3:0] req, input logic done, input logic clr);
      Req = req; Done = done; Clear = clr;
      @(posedge Clk);
      model_edge(req, done, clr);
      #5;
   endtask

   task automatic test_reset();
      cycle(4'b1111, 1'b0, 1'b1);
      cycle(4'b1111, 1'b0, 1'b1);
      n_checks++; if (Grant !== 4'b0000) $display("FAIL reset_grant got %b exp 0000", Grant); else n_pass++;
      n_checks++; if (Busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", Busy); else n_pass++;
      n_checks++; if (Grant_index !== 4'd0) $display("FAIL reset_index got %0d exp 0", Grant_index); else n_pass++;
      n_checks++; if (Timeout !== 1'b0) $display("FAIL reset_timeout got %b exp 0", Timeout); else n_pass++;
      cycle(4'b1111, 1'b0, 1'b0);
      n_checks++; if (Grant !== 4'b0001) $display("FAIL reset_first_grant got %b exp 0001", Grant); else n_pass++;
      n_checks++; if (Grant_index !== 4'd0) $display("FAIL reset_first_index got %0d exp 0", Grant_index); else n_pass++;
   endtask

   task automatic test_rotation();
      logic [3:0] exp_g [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0] exp_i [4] = '{4'd1, 4'd2, 4'd3, 4'd0};
      for (int i = 0; i < 4; i++) begin
         cycle(4'b1111, 1'b1, 1'b0);
         n_checks++; if (Grant !== exp_g[i]) $display("FAIL rot_grant%0d got %b exp %b", i, Grant, exp_g[i]); else n_pass++;
         n_checks++; if (Grant_index !== exp_i[i]) $display("FAIL rot_index%0d got %0d exp %0d", i, Grant_index, exp_i[i]); else n_pass++;
         n_checks++; if (Busy !== 1'b1) $display("FAIL rot_busy%0d got %b exp 1", i, Busy); else n_pass++;
      end
   endtask

   task automatic test_withdraw();
      cycle(4'b0000, 1'b0, 1'b1);
      cycle(4'b0100, 1'b0, 1'b0);
      n_checks++; if (Grant !== 4'b0100) $display("FAIL wd_grant got %b exp 0100", Grant); else n_pass++;
      cycle(4'b0000, 1'b0, 1'b0);
      n_checks++; if (Grant !== 4'b0000) $display("FAIL wd_idle_grant got %b exp 0000", Grant); else n_pass++;
      n_checks++; if (Busy !== 1'b0) $display("FAIL wd_idle_busy got %b exp 0", Busy); else n_pass++;
      cycle(4'b0000, 1'b1, 1'b0);
      n_checks++; if (Busy !== 1'b0) $display("FAIL wd_done_idle got %b exp 0", Busy); else n_pass++;
      cycle(4'b0110, 1'b0, 1'b0);
      n_checks++; if (Grant !== 4'b0010) $display("FAIL wd_wrap_grant got %b exp 0010", Grant); else n_pass++;
      n_checks++; if (Grant_index !== 4'd1) $display("FAIL wd_wrap_index got %0d exp 1", Grant_index); else n_pass++;
   endtask

   task automatic test_hold();
      int bad;
      cycle(4'b0000, 1'b0, 1'b1);
      cycle(4'b0001, 1'b0, 1'b0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(4'b0001, 1'b0, 1'b0);
         if (Grant !== 4'b0001 || Timeout !== 1'b0) bad++;
      end
      n_checks++; if (bad != 0) $display("FAIL hold_stable got %0d bad cycles exp 0", bad); else n_pass++;
      cycle(4'b1001, 1'b1, 1'b0);
      n_checks++; if (Grant !== 4'b1000) $display("FAIL hold_b2b_grant got %b exp 1000", Grant); else n_pass++;
      n_checks++; if (Busy !== 1'b1) $display("FAIL hold_b2b_busy got %b exp 1", Busy); else n_pass++;
   endtask

   task automatic test_clear_mid();
      cycle(4'b0000, 1'b0, 1'b1);
      cycle(4'b0100, 1'b0, 1'b0);
      n_checks++; if (Grant !== 4'b0100) $display("FAIL cm_grant got %b exp 0100", Grant); else n_pass++;
      cycle(4'b0100, 1'b0, 1'b1);
      n_checks++; if (Grant !== 4'b0000) $display("FAIL cm_cleared got %b exp 0000", Grant); else n_pass++;
      cycle(4'b0110, 1'b0, 1'b0);
      n_checks++; if (Grant !== 4'b0010) $display("FAIL cm_ptr0_grant got %b exp 0010", Grant); else n_pass++;
   endtask

`ifdef TTL_ARB_TIMEOUT_EN
   task automatic test_timeout();
      cycle(4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(4'b0011, 1'b0, 1'b0);
         n_checks++; if (Grant !== 4'b0001 || Timeout !== 1'b0) $display("FAIL to_hold%0d got %b/%b exp 0001/0", i, Grant, Timeout); else n_pass++;
      end
      cycle(4'b0011, 1'b0, 1'b0);
      n_checks++; if (Grant !== 4'b0010) $display("FAIL to_forced_grant got %b exp 0010", Grant); else n_pass++;
      n_checks++; if (Timeout !== 1'b1) $display("FAIL to_pulse got %b exp 1", Timeout); else n_pass++;
      cycle(4'b0011, 1'b0, 1'b0);
      n_checks++; if (Timeout !== 1'b0) $display("FAIL to_pulse_end got %b exp 0", Timeout); else n_pass++;
   endtask
`endif

   task automatic test_random();
      logic [3:0] eg;
      logic [3:0] ei;
      cycle(4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 400; i++) begin
         cycle(4'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
         eg = '0;
         ei = '0;
         if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ei = 4'(m_owner);
         end
         n_checks++; if (Grant !== eg) $display("FAIL rnd_grant c%0d got %b exp %b", i, Grant, eg); else n_pass++;
         n_checks++; if (Grant_index !== ei) $display("FAIL rnd_index c%0d got %0d exp %0d", i, Grant_index, ei); else n_pass++;
         n_checks++; if (Busy !== (m_owner >= 0)) $display("FAIL rnd_busy c%0d got %b exp %b", i, Busy, (m_owner >= 0)); else n_pass++;
         n_checks++; if (Timeout !== m_tmo) $display("FAIL rnd_timeout c%0d got %b exp %b", i, Timeout, m_tmo); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_withdraw();
`ifndef TTL_ARB_TIMEOUT_EN
      test_hold();
`endif
      test_clear_mid();
`ifdef TTL_ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
